piezo_phase_generator: RTL and testbench

//  Per-channel phase-shifted square-wave source for the levitation transducer array.

---
 rtl/piezo_phase_generator.sv | 143 ++++++++++++++
 tb/tb_piezo_phase_generator.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piezo_phase_generator.sv
// Phase-shifted square-wave source for the transducer array. A shadow phase
// bank is written by the host and copied to the active bank on a period boundary.
module piezo_phase_generator #(
   parameter int NUM_CH   = 89,
   parameter int PHASE_W  = 8,
   parameter int STEP_DIV = 5,
   parameter int STEPS    = 250
) (
   input  logic               clk_clk,
   input  logic               reset_reset,
   input  logic               enable,
   input  logic               wr_en,
   input  logic [6:0]         wr_addr,
   input  logic [PHASE_W-1:0] wr_data,
   input  logic               commit,
   input  logic               err_clr,
   output logic [NUM_CH-1:0]  piezo_out,
   output logic               piezo_enable,
   output logic [2:0]         piezo_status,
   output logic               sync_out,
   output logic               commit_done
);

   localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   typedef logic [PHASE_W:0] ext_t;

   localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(STEP_DIV - 1);
   localparam logic [PHASE_W-1:0] STEP_LAST = PHASE_W'(STEPS - 1);
   localparam ext_t               STEPS_X   = ext_t'(STEPS);
   localparam ext_t               HALF_X    = ext_t'(STEPS / 2);
   localparam logic [7:0]         NCH_X     = 8'(NUM_CH);

   // Modular distance from the channel's phase to the current step, compared
   // against half a period to give a 50% duty square wave.
   function automatic logic phase_high(input logic [PHASE_W-1:0] step_v,
                                       input logic [PHASE_W-1:0] ph);
      ext_t s;
      ext_t p;
      ext_t d;
      s = {1'b0, step_v};
      p = {1'b0, ph};
      d = (s >= p) ? (s - p) : (s + STEPS_X - p);
      return d < HALF_X;
   endfunction

   logic               run;
   logic [DIV_W-1:0]   div;
   logic [PHASE_W-1:0] step;
   logic               pending;
   logic               err_sticky;
   logic [PHASE_W-1:0] shadow [NUM_CH];
   logic [PHASE_W-1:0] active [NUM_CH];

   logic wr_ok;
   logic wr_bad;
   logic wrap_evt;
   logic load;

   assign wr_ok    = wr_en && ({1'b0, wr_addr} < NCH_X) && ({1'b0, wr_data} < STEPS_X);
   assign wr_bad   = wr_en && !wr_ok;
   assign wrap_evt = run && (div == DIV_LAST) && (step == STEP_LAST);
   // While stopped a pending commit lands immediately; while running it waits for the wrap.
   assign load     = pending && (wrap_evt || !run);

   assign piezo_status = {pending, run, err_sticky};

   // Carrier timebase
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         run  <= 1'b0;
         div  <= '0;
         step <= '0;
      end else begin
         run <= enable;
         if (!run) begin
            div  <= '0;
            step <= '0;
         end else if (div == DIV_LAST) begin
            div  <= '0;
            step <= (step == STEP_LAST) ? '0 : step + 1'b1;
         end else begin
            div <= div + 1'b1;
         end
      end
   end

   // Commit / error control
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         pending     <= 1'b0;
         err_sticky  <= 1'b0;
         commit_done <= 1'b0;
      end else begin
         if (load) begin
            pending <= 1'b0;
         end else if (commit) begin
            pending <= 1'b1;
         end
         if (wr_bad) begin
            err_sticky <= 1'b1;
         end else if (err_clr) begin
            err_sticky <= 1'b0;
         end
         commit_done <= load;
      end
   end

   // Phase banks: the copy reads shadow before this cycle's write lands
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         if (wr_ok) begin
            shadow[wr_addr] <= wr_data;
         end
         if (load) begin
            for (int i = 0; i < NUM_CH; i++) begin
               active[i] <= shadow[i];
            end
         end
      end
   end

   // Output register stage
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         piezo_out    <= '0;
         piezo_enable <= 1'b0;
         sync_out     <= 1'b0;
      end else begin
         piezo_enable <= run;
         sync_out     <= run && (div == '0) && (step == '0);
         for (int i = 0; i < NUM_CH; i++) begin
            piezo_out[i] <= run && phase_high(step, active[i]);
         end
      end
   end

endmodule

// File: tb/tb_piezo_phase_generator.sv
// Directed bench for piezo_phase_generator: carrier shape tables, write/error
// table, and hand sequences for commit timing, enable drop and reset.
module tb_piezo_phase_generator;

   localparam int NUM_CH = 89;

   logic              clk;
   logic              rst;
   logic              enable;
   logic              wr_en;
   logic [6:0]        wr_addr;
   logic [7:0]        wr_data;
   logic              commit;
   logic              err_clr;
   logic [NUM_CH-1:0] piezo_out;
   logic              piezo_enable;
   logic [2:0]        piezo_status;
   logic              sync_out;
   logic              commit_done;

   piezo_phase_generator dut (
      .clk_clk      (clk),
      .reset_reset  (rst),
      .enable       (enable),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .commit       (commit),
      .err_clr      (err_clr),
      .piezo_out    (piezo_out),
      .piezo_enable (piezo_enable),
      .piezo_status (piezo_status),
      .sync_out     (sync_out),
      .commit_done  (commit_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int   off;
      logic sync;
      logic base;
      logic ch5;
   } car_vec_t;

   typedef struct {
      logic [6:0] addr;
      logic [7:0] data;
      logic       wr;
      logic       clr;
      logic       err;
   } wr_vec_t;

   car_vec_t car_tab [11];
   wr_vec_t  wr_tab  [8];

   int n_vec = 0;
   int n_err = 0;
   logic [NUM_CH-1:0] m5;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic adv(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_sync(input string name);
      for (int i = 0; i < 1300; i++) begin
         @(negedge clk);
         if (sync_out) return;
      end
      n_vec++;
      n_err++;
      $display("FAIL %s: sync_out got 0 expected 1 within 1300 cycles", name);
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 1300; i++) begin
         @(negedge clk);
         if (commit_done) return;
      end
      n_vec++;
      n_err++;
      $display("FAIL %s: commit_done got 0 expected 1 within 1300 cycles", name);
   endtask

   // Offsets are cycles after the sample where sync_out is seen high.
   task automatic run_table(input int first, input int last);
      int cur;
      cur = 0;
      for (int i = first; i <= last; i++) begin
         adv(car_tab[i].off - cur);
         cur = car_tab[i].off;
         check($sformatf("tab%0d_sync", i), 128'(sync_out), 128'(car_tab[i].sync));
         check($sformatf("tab%0d_ch5", i), 128'(piezo_out[5]), 128'(car_tab[i].ch5));
         check($sformatf("tab%0d_others", i), 128'(piezo_out & ~m5),
               128'({NUM_CH{car_tab[i].base}} & ~m5));
      end
   endtask

   task automatic pulse_commit();
      commit = 1'b1;
      adv(1);
      commit = 1'b0;
   endtask

   task automatic write_ch(input logic [6:0] a, input logic [7:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      adv(1);
      wr_en   = 1'b0;
   endtask

   initial begin
      m5 = '0;
      m5[5] = 1'b1;

      // all phases 0
      car_tab[0]  = '{0,    1'b1, 1'b1, 1'b1};
      car_tab[1]  = '{1,    1'b0, 1'b1, 1'b1};
      car_tab[2]  = '{624,  1'b0, 1'b1, 1'b1};
      car_tab[3]  = '{625,  1'b0, 1'b0, 1'b0};
      car_tab[4]  = '{1249, 1'b0, 1'b0, 1'b0};
      car_tab[5]  = '{1250, 1'b1, 1'b1, 1'b1};
      // ch5 at phase 125: inverted
      car_tab[6]  = '{0,    1'b1, 1'b1, 1'b0};
      car_tab[7]  = '{624,  1'b0, 1'b1, 1'b0};
      car_tab[8]  = '{625,  1'b0, 1'b0, 1'b1};
      car_tab[9]  = '{1249, 1'b0, 1'b0, 1'b1};
      car_tab[10] = '{1250, 1'b1, 1'b1, 1'b0};

      wr_tab[0] = '{7'd3,   8'd10,  1'b1, 1'b0, 1'b0};
      wr_tab[1] = '{7'd89,  8'd10,  1'b1, 1'b0, 1'b1};
      wr_tab[2] = '{7'd0,   8'd0,   1'b0, 1'b1, 1'b0};
      wr_tab[3] = '{7'd2,   8'd250, 1'b1, 1'b0, 1'b1};
      wr_tab[4] = '{7'd88,  8'd249, 1'b1, 1'b0, 1'b1};
      wr_tab[5] = '{7'd1,   8'd255, 1'b1, 1'b1, 1'b1};
      wr_tab[6] = '{7'd0,   8'd0,   1'b0, 1'b1, 1'b0};
      wr_tab[7] = '{7'd0,   8'd0,   1'b1, 1'b0, 1'b0};

      rst = 1'b1;
      enable = 1'b0;
      wr_en = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      commit = 1'b0;
      err_clr = 1'b0;

      adv(3);
      check("rst_out", 128'(piezo_out), 128'(0));
      check("rst_en", 128'(piezo_enable), 128'(0));
      check("rst_status", 128'(piezo_status), 128'(0));
      check("rst_sync", 128'(sync_out), 128'(0));
      check("rst_done", 128'(commit_done), 128'(0));

      // Carrier with all phases 0
      rst = 1'b0;
      enable = 1'b1;
      wait_sync("first_sync");
      run_table(0, 5);

      // ch5 = 125, commit while running
      write_ch(7'd5, 8'd125);
      pulse_commit();
      check("t2_pending", 128'(piezo_status[2]), 128'(1));
      wait_done("t2_done");
      check("t2_pending_clr", 128'(piezo_status[2]), 128'(0));
      wait_sync("t2_sync");
      run_table(6, 10);

      // Mid-period commit: ch5 back to 0, write and commit in the same cycle
      adv(100);
      wr_en = 1'b1;
      wr_addr = 7'd5;
      wr_data = 8'd0;
      commit = 1'b1;
      adv(1);
      wr_en = 1'b0;
      commit = 1'b0;
      check("t3_pend_a", 128'(piezo_status[2]), 128'(1));
      check("t3_done_a", 128'(commit_done), 128'(0));
      adv(599);
      check("t3_old_bank", 128'({piezo_out[5], piezo_out[0]}), 128'(2'b10));
      adv(548);
      check("t3_pend_b", 128'(piezo_status[2]), 128'(1));
      check("t3_done_b", 128'(commit_done), 128'(0));
      adv(1);
      check("t3_done_c", 128'(commit_done), 128'(1));
      check("t3_pend_c", 128'(piezo_status[2]), 128'(0));
      check("t3_last_old", 128'({piezo_out[5], piezo_out[0]}), 128'(2'b10));
      adv(1);
      check("t3_sync", 128'(sync_out), 128'(1));
      check("t3_done_d", 128'(commit_done), 128'(0));
      check("t3_new_bank", 128'({piezo_out[5], piezo_out[0]}), 128'(2'b11));

      // Write legality and sticky error
      for (int i = 0; i < 8; i++) begin
         wr_en = wr_tab[i].wr;
         wr_addr = wr_tab[i].addr;
         wr_data = wr_tab[i].data;
         err_clr = wr_tab[i].clr;
         adv(1);
         wr_en = 1'b0;
         err_clr = 1'b0;
         check($sformatf("wr%0d_err", i), 128'(piezo_status[0]), 128'(wr_tab[i].err));
      end
      pulse_commit();
      wait_done("t4_done");
      wait_sync("t4_sync");
      adv(5);
      check("t4_step1", 128'({piezo_out[88], piezo_out[3], piezo_out[2], piezo_out[1], piezo_out[0]}),
            128'(5'b10111));
      adv(630);
      check("t4_step127", 128'({piezo_out[88], piezo_out[3], piezo_out[2], piezo_out[1], piezo_out[0]}),
            128'(5'b01000));
      wait_sync("t4_sync_b");

      // Write landing on the applying wrap cycle stays in shadow only
      write_ch(7'd4, 8'd125);
      pulse_commit();
      adv(1246);
      wr_en = 1'b1;
      wr_addr = 7'd3;
      wr_data = 8'd125;
      adv(1);
      wr_en = 1'b0;
      check("t5_done", 128'(commit_done), 128'(1));
      adv(1);
      check("t5_sync", 128'(sync_out), 128'(1));
      adv(250);
      check("t5_old_ch3", 128'({piezo_out[4], piezo_out[3], piezo_out[0]}), 128'(3'b011));
      pulse_commit();
      wait_done("t5_done_b");
      wait_sync("t5_sync_b");
      adv(250);
      check("t5_new_s50", 128'({piezo_out[4], piezo_out[3], piezo_out[0]}), 128'(3'b001));
      adv(750);
      check("t5_new_s200", 128'({piezo_out[4], piezo_out[3], piezo_out[0]}), 128'(3'b110));

      // Pending commit then enable drop
      pulse_commit();
      check("t6_pend", 128'(piezo_status[2]), 128'(1));
      enable = 1'b0;
      adv(1);
      check("t6_run_off", 128'(piezo_status[1]), 128'(0));
      check("t6_done_a", 128'(commit_done), 128'(0));
      adv(1);
      check("t6_done_b", 128'(commit_done), 128'(1));
      check("t6_pend_clr", 128'(piezo_status[2]), 128'(0));
      check("t6_out_off", 128'(piezo_out), 128'(0));
      check("t6_en_off", 128'(piezo_enable), 128'(0));
      adv(3);
      check("t6_out_idle", 128'(piezo_out), 128'(0));
      check("t6_sync_idle", 128'(sync_out), 128'(0));

      // Re-enable: sync on the first running cycle's output
      enable = 1'b1;
      adv(1);
      check("t6_sync_a", 128'(sync_out), 128'(0));
      check("t6_run_on", 128'(piezo_status[1]), 128'(1));
      adv(1);
      check("t6_sync_b", 128'(sync_out), 128'(1));
      check("t6_ch0_on", 128'(piezo_out[0]), 128'(1));
      check("t6_en_on", 128'(piezo_enable), 128'(1));
      adv(300);
      check("t6_pre_rst", 128'(piezo_out[0]), 128'(1));

      // Asynchronous reset mid-run
      #2 rst = 1'b1;
      #1;
      check("arst_out", 128'(piezo_out), 128'(0));
      check("arst_en", 128'(piezo_enable), 128'(0));
      check("arst_status", 128'(piezo_status), 128'(0));
      check("arst_sync", 128'(sync_out), 128'(0));
      check("arst_done", 128'(commit_done), 128'(0));
      adv(1);
      rst = 1'b0;
      adv(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
